// File: rtl/wb_bus_if_pkg.sv
// Shared defines for the Wishbone bus interface: reset/stall levels, bus width and FSM states.
package wb_bus_if_pkg;

    localparam logic RstEnable = 1'b1;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam int   RegBus    = 32;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } bus_state_t;

endpackage

// File: rtl/wb_bus_if_if.sv
// Wishbone master/slave signal bundle used between wb_bus_if and the bus fabric.
interface wb_bus_if_if;
    import wb_bus_if_pkg::*;

    logic [RegBus-1:0] wb_adr_o;
    logic [RegBus-1:0] wb_dat_o;
    logic [3:0]        wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic [RegBus-1:0] wb_dat_i;
    logic              wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/wb_bus_if.sv
// CPU-to-Wishbone bridge: one access at a time, result held while the pipeline is stalled elsewhere.
// Define WB_TIMEOUT_EN to abort accesses that see no wb_ack_i within TIMEOUT_CYC cycles.
module wb_bus_if
    import wb_bus_if_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [RegBus-1:0] cpu_addr_i,
    input  logic [3:0]        cpu_sel_i,
    input  logic [RegBus-1:0] cpu_data_i,
    output logic [RegBus-1:0] cpu_data_o,
    output logic              stallreq,
    wb_bus_if_if.master       wb,
    output logic              bus_err_o
);

    bus_state_t        r_state;
    bus_state_t        w_nextState;
    logic [RegBus-1:0] r_adr;
    logic [RegBus-1:0] r_dat;
    logic [3:0]        r_sel;
    logic              r_we;
    logic              r_cyc;
    logic              r_stb;
    logic [RegBus-1:0] r_rdBuf;
    logic              w_accept;
    logic              w_done;
    logic              w_drop;
    logic              w_timeout;

`ifdef WB_TIMEOUT_EN
    localparam int CntW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYC);
    logic [CntW-1:0] r_cnt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = |TIMEOUT_CYC;
`endif

    assign wb.wb_adr_o = r_adr;
    assign wb.wb_dat_o = r_dat;
    assign wb.wb_sel_o = r_sel;
    assign wb.wb_we_o  = r_we;
    assign wb.wb_cyc_o = r_cyc;
    assign wb.wb_stb_o = r_stb;
    assign bus_err_o   = w_timeout;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) r_state <= IDLE;
        else                  r_state <= w_nextState;
    end

    // Flush outranks ack, and ack outranks timeout, so a late ack never delivers discarded data.
    always_comb begin
        w_nextState = r_state;
        stallreq    = NoStop;
        cpu_data_o  = ZeroWord;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_drop      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_ce_i && !flush) begin
                    stallreq    = Stop;
                    w_accept    = 1'b1;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    w_drop      = 1'b1;
                    w_nextState = IDLE;
                end else if (wb.wb_ack_i) begin
                    w_done      = 1'b1;
                    cpu_data_o  = r_we ? ZeroWord : wb.wb_dat_i;
                    w_nextState = (stall == 6'b0) ? IDLE : WAIT_STALL;
`ifdef WB_TIMEOUT_EN
                end else if (r_cnt == TimeoutVal) begin
                    w_timeout   = 1'b1;
                    w_drop      = 1'b1;
                    cpu_data_o  = 32'hFFFF_FFFF;
                    w_nextState = IDLE;
`endif
                end else begin
                    stallreq = Stop;
                end
            end
            WAIT_STALL: begin
                if (flush) begin
                    w_nextState = IDLE;
                end else begin
                    cpu_data_o = r_rdBuf;
                    if (stall == 6'b0) w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
        if (rst == RstEnable) begin
            stallreq   = NoStop;
            cpu_data_o = ZeroWord;
            w_timeout  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_adr   <= ZeroWord;
            r_dat   <= ZeroWord;
            r_sel   <= 4'b0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_rdBuf <= ZeroWord;
        end else if (w_accept) begin
            r_adr <= cpu_addr_i;
            r_dat <= cpu_data_i;
            r_sel <= cpu_sel_i;
            r_we  <= cpu_we_i;
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
        end else if (w_done) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_rdBuf <= r_we ? ZeroWord : wb.wb_dat_i;
        end else if (w_drop) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst || flush || w_accept || w_done || w_timeout) r_cnt <= '0;
        else if (r_state == BUSY)                           r_cnt <= r_cnt + CntW'(1);
    end
`endif

endmodule

// File: tb/tb_wb_bus_if.sv
// Directed bench for wb_bus_if: a per-cycle vector table plus hand-written stall/flush/timeout sequences.
module tb_wb_bus_if;
    import wb_bus_if_pkg::*;

    typedef struct {
        logic        rst;
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [5:0]  stall;
        logic        flush;
        logic        ack;
        logic [31:0] rdata;
        logic        expStall;
        logic [31:0] expData;
        logic        expCyc;
        logic        expStb;
        logic        expWe;
        logic [3:0]  expSel;
        logic [31:0] expAdr;
        logic [31:0] expDat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cpuCe;
    logic        cpuWe;
    logic [31:0] cpuAddr;
    logic [3:0]  cpuSel;
    logic [31:0] cpuDataIn;
    logic [31:0] cpuDataOut;
    logic        stallReq;
    logic        busErr;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[14];

    wb_bus_if_if wbBus();

    wb_bus_if #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .cpu_ce_i  (cpuCe),
        .cpu_we_i  (cpuWe),
        .cpu_addr_i(cpuAddr),
        .cpu_sel_i (cpuSel),
        .cpu_data_i(cpuDataIn),
        .cpu_data_o(cpuDataOut),
        .stallreq  (stallReq),
        .wb        (wbBus),
        .bus_err_o (busErr)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic c, input logic w,
                                 input logic [31:0] a, input logic [3:0] s,
                                 input logic [31:0] d, input logic [5:0] st,
                                 input logic f, input logic k, input logic [31:0] rd);
        rst            = r;
        cpuCe          = c;
        cpuWe          = w;
        cpuAddr        = a;
        cpuSel         = s;
        cpuDataIn      = d;
        stall          = st;
        flush          = f;
        wbBus.wb_ack_i = k;
        wbBus.wb_dat_i = rd;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 0, 32'h0);
    endtask

    initial begin
        // rst ce we addr sel wdata stall flush ack rdata | stallreq data cyc stb we sel adr dat
        vecs[0]  = '{1,1,1,32'h99,4'hF,32'h77,  6'h0,0,1,32'h55,       0,32'h0,       0,0,0,4'h0,32'h0, 32'h0};
        vecs[1]  = '{0,1,0,32'h10,4'hF,32'h0,   6'h0,0,0,32'h0,        1,32'h0,       0,0,0,4'h0,32'h0, 32'h0};
        vecs[2]  = '{0,1,0,32'h10,4'hF,32'h0,   6'h0,0,0,32'h0,        1,32'h0,       1,1,0,4'hF,32'h10,32'h0};
        vecs[3]  = '{0,1,0,32'h10,4'hF,32'h0,   6'h0,0,0,32'h0,        1,32'h0,       1,1,0,4'hF,32'h10,32'h0};
        vecs[4]  = '{0,1,0,32'h10,4'hF,32'h0,   6'h0,0,0,32'h0,        1,32'h0,       1,1,0,4'hF,32'h10,32'h0};
        vecs[5]  = '{0,1,0,32'h10,4'hF,32'h0,   6'h0,0,1,32'hDEADBEEF, 0,32'hDEADBEEF,1,1,0,4'hF,32'h10,32'h0};
        vecs[6]  = '{0,0,0,32'h0, 4'h0,32'h0,   6'h0,0,1,32'h12345678, 0,32'h0,       0,0,0,4'hF,32'h10,32'h0};
        vecs[7]  = '{0,1,1,32'h20,4'h3,32'h1234,6'h0,0,0,32'h0,        1,32'h0,       0,0,0,4'hF,32'h10,32'h0};
        vecs[8]  = '{0,1,1,32'h20,4'h3,32'h1234,6'h0,0,0,32'h0,        1,32'h0,       1,1,1,4'h3,32'h20,32'h1234};
        vecs[9]  = '{0,1,1,32'h20,4'h3,32'h1234,6'h0,0,1,32'hAAAA5555, 0,32'h0,       1,1,1,4'h3,32'h20,32'h1234};
        vecs[10] = '{0,0,0,32'h0, 4'h0,32'h0,   6'h0,0,0,32'h0,        0,32'h0,       0,0,0,4'h3,32'h20,32'h1234};
        vecs[11] = '{0,1,0,32'h30,4'hF,32'h0,   6'h0,0,0,32'h0,        1,32'h0,       0,0,0,4'h3,32'h20,32'h1234};
        vecs[12] = '{1,1,0,32'h30,4'hF,32'h0,   6'h0,0,1,32'hBEEF,     0,32'h0,       1,1,0,4'hF,32'h30,32'h0};
        vecs[13] = '{0,0,0,32'h0, 4'h0,32'h0,   6'h0,0,0,32'h0,        0,32'h0,       0,0,0,4'h0,32'h0, 32'h0};

        applyStimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 0, 32'h0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].sel,
                          vecs[i].wdata, vecs[i].stall, vecs[i].flush, vecs[i].ack, vecs[i].rdata);
            checkOutput($sformatf("v%0d_stallreq", i), {31'b0, stallReq},       {31'b0, vecs[i].expStall});
            checkOutput($sformatf("v%0d_cpu_data", i), cpuDataOut,              vecs[i].expData);
            checkOutput($sformatf("v%0d_cyc", i),      {31'b0, wbBus.wb_cyc_o}, {31'b0, vecs[i].expCyc});
            checkOutput($sformatf("v%0d_stb", i),      {31'b0, wbBus.wb_stb_o}, {31'b0, vecs[i].expStb});
            checkOutput($sformatf("v%0d_we", i),       {31'b0, wbBus.wb_we_o},  {31'b0, vecs[i].expWe});
            checkOutput($sformatf("v%0d_sel", i),      {28'b0, wbBus.wb_sel_o}, {28'b0, vecs[i].expSel});
            checkOutput($sformatf("v%0d_adr", i),      wbBus.wb_adr_o,          vecs[i].expAdr);
            checkOutput($sformatf("v%0d_dat", i),      wbBus.wb_dat_o,          vecs[i].expDat);
            @(negedge clk);
        end

        // Read acked under an external stall: result must stay visible until stall clears.
        applyStimulus(0, 1, 0, 32'h40, 4'hF, 32'h0, 6'h0, 0, 0, 32'h0);
        checkOutput("stl_req_idle", {31'b0, stallReq}, 32'd1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 6'b001111, 0, 1, 32'hCAFEF00D);
        checkOutput("stl_ack_req", {31'b0, stallReq}, 32'd0);
        checkOutput("stl_ack_data", cpuDataOut, 32'hCAFEF00D);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 6'b001111, 0, 1, 32'h0BAD0BAD);
            checkOutput($sformatf("stl_hold_data%0d", k), cpuDataOut, 32'hCAFEF00D);
            checkOutput($sformatf("stl_hold_req%0d", k), {31'b0, stallReq}, 32'd0);
            checkOutput($sformatf("stl_hold_cyc%0d", k), {31'b0, wbBus.wb_cyc_o}, 32'd0);
            @(negedge clk);
        end
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 0, 32'h0);
        checkOutput("stl_release_data", cpuDataOut, 32'hCAFEF00D);
        @(negedge clk);
        idleCycle();
        checkOutput("stl_idle_data", cpuDataOut, 32'h0);
        checkOutput("stl_idle_req", {31'b0, stallReq}, 32'd0);
        @(negedge clk);

        // Flush in the second BUSY cycle, followed by a late ack.
        applyStimulus(0, 1, 0, 32'h50, 4'hF, 32'h0, 6'h0, 0, 0, 32'h0);
        @(negedge clk);
        idleCycle();
        checkOutput("fl_busy1_req", {31'b0, stallReq}, 32'd1);
        checkOutput("fl_busy1_cyc", {31'b0, wbBus.wb_cyc_o}, 32'd1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 1, 0, 32'h0);
        checkOutput("fl_req", {31'b0, stallReq}, 32'd0);
        checkOutput("fl_data", cpuDataOut, 32'h0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 1, 32'h5A5A5A5A);
        checkOutput("fl_after_cyc", {31'b0, wbBus.wb_cyc_o}, 32'd0);
        checkOutput("fl_after_stb", {31'b0, wbBus.wb_stb_o}, 32'd0);
        checkOutput("fl_late_ack_data", cpuDataOut, 32'h0);
        checkOutput("fl_late_ack_req", {31'b0, stallReq}, 32'd0);
        @(negedge clk);
        idleCycle();
        checkOutput("fl_settle_cyc", {31'b0, wbBus.wb_cyc_o}, 32'd0);
        @(negedge clk);

        // Flush and ack together, with stall raised so an ack win would park in WAIT_STALL.
        applyStimulus(0, 1, 0, 32'h60, 4'hF, 32'h0, 6'h0, 0, 0, 32'h0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 6'b000001, 1, 1, 32'h11112222);
        checkOutput("fa_req", {31'b0, stallReq}, 32'd0);
        checkOutput("fa_data", cpuDataOut, 32'h0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 6'b000001, 0, 0, 32'h0);
        checkOutput("fa_after_data", cpuDataOut, 32'h0);
        checkOutput("fa_after_cyc", {31'b0, wbBus.wb_cyc_o}, 32'd0);
        @(negedge clk);
        idleCycle();
        @(negedge clk);

`ifdef WB_TIMEOUT_EN
        applyStimulus(0, 1, 0, 32'h70, 4'hF, 32'h0, 6'h0, 0, 0, 32'h0);
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            idleCycle();
            checkOutput($sformatf("to_busy%0d_err", k), {31'b0, busErr}, 32'd0);
            checkOutput($sformatf("to_busy%0d_req", k), {31'b0, stallReq}, 32'd1);
            @(negedge clk);
        end
        idleCycle();
        checkOutput("to_err_pulse", {31'b0, busErr}, 32'd1);
        checkOutput("to_err_data", cpuDataOut, 32'hFFFF_FFFF);
        checkOutput("to_err_req", {31'b0, stallReq}, 32'd0);
        @(negedge clk);
        idleCycle();
        checkOutput("to_after_err", {31'b0, busErr}, 32'd0);
        checkOutput("to_after_cyc", {31'b0, wbBus.wb_cyc_o}, 32'd0);
        @(negedge clk);
`else
        applyStimulus(0, 1, 0, 32'h70, 4'hF, 32'h0, 6'h0, 0, 0, 32'h0);
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            idleCycle();
            checkOutput($sformatf("nt_busy%0d_err", k), {31'b0, busErr}, 32'd0);
            checkOutput($sformatf("nt_busy%0d_req", k), {31'b0, stallReq}, 32'd1);
            checkOutput($sformatf("nt_busy%0d_cyc", k), {31'b0, wbBus.wb_cyc_o}, 32'd1);
            @(negedge clk);
        end
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 1, 32'h76543210);
        checkOutput("nt_ack_data", cpuDataOut, 32'h76543210);
        checkOutput("nt_ack_req", {31'b0, stallReq}, 32'd0);
        @(negedge clk);
        idleCycle();
        checkOutput("nt_after_cyc", {31'b0, wbBus.wb_cyc_o}, 32'd0);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
